// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8-N-1 MIDI serial receiver. Define MIDI_RX_MAJORITY_VOTE_EN to take each sample as a 2-of-3 vote.
// Latency: the strobe arrives 3 + HALF_TICKS + 9*BIT_TICKS cycles after the start-bit pin edge (15203 at defaults).
// No backpressure: every data_out_ready / framing_error strobe must be taken in the cycle it appears.
module midi_uart_rx #(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int BAUD     = 31_250
) (
    input  logic       clock_50_000_000,
    input  logic       reset,
    input  logic       midi_rx,
    output logic [7:0] data_out,
    output logic       data_out_ready,
    output logic       framing_error
);
    localparam int BIT_TICKS  = CLOCK_HZ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CW         = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    data_nxt;
    logic          ready_nxt, ferr_nxt;
    logic          rx_meta, rx_s;
    logic          sample;

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= midi_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef MIDI_RX_MAJORITY_VOTE_EN
    // Two previous rx_s values plus the current one form the votes at cnt = N-3, N-2, N-1.
    logic [1:0] rx_hist;
    always_ff @(posedge clock_50_000_000) begin
        if (reset) rx_hist <= 2'b11;
        else       rx_hist <= {rx_hist[0], rx_s};
    end
    assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state          <= WAIT_IDLE;
            cnt            <= '0;
            bit_idx        <= 3'd0;
            shift          <= 8'h00;
            data_out       <= 8'h00;
            data_out_ready <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bit_idx        <= bit_idx_nxt;
            shift          <= shift_nxt;
            data_out       <= data_nxt;
            data_out_ready <= ready_nxt;
            framing_error  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_ONE;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        data_nxt    = data_out;
        ready_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            WAIT_IDLE: begin
                // Re-arm only after a full bit time of continuous idle-high line.
                if (!rx_s) begin
                    cnt_nxt = '0;
                end else if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (sample) begin
                        state_nxt = IDLE;
                    end else begin
                        bit_idx_nxt = 3'd0;
                        state_nxt   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {sample, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (sample) begin
                        data_nxt  = shift;
                        ready_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_IDLE;
            end
        endcase
    end
endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial receiver for the MIDI input pin. It recovers 8-N-1 bytes at 31 250 baud from the asynchronous line and presents each one as a byte plus a one-cycle strobe. It sits directly upstream of the MIDI decoder: its `data_out` / `data_out_ready` drive the decoder's `data_in` / `data_in_ready`. The block runs entirely in the 50 MHz domain.

## Interface

Parameters:
- `CLOCK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 31_250: line rate.
- `BIT_TICKS` (localparam) = `CLOCK_HZ/BAUD` = 1600.
- `HALF_TICKS` (localparam) = `BIT_TICKS/2` = 800.

Ports:
- `clock_50_000_000`, in, 1: sole clock. One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `midi_rx`, in, 1: asynchronous serial line; idle high.
- `data_out`, out, 8: last good byte, LSB received first.
- `data_out_ready`, out, 1: one-cycle strobe; `data_out` is valid in the same cycle.
- `framing_error`, out, 1: one-cycle strobe when the stop bit samples low.

## Operation

- **Synchronizer:** two flops on `midi_rx` produce `rx_s`. Both flops reset to 1. All logic uses `rx_s` only.
- **Counter:** `cnt` is `$clog2(BIT_TICKS)` = 11 bits, unsigned. It is cleared on every state change and increments by 1 per cycle otherwise. `bit_idx` is 3 bits. `shift` is 8 bits; each data bit enters at the MSB and the register shifts right.
- **FSM states:**
  - WAIT_IDLE: `cnt` counts while `rx_s`=1 and clears when `rx_s`=0. When `cnt`==BIT_TICKS-1 with `rx_s`=1, go to IDLE. Reset enters this state, so a line held low never produces a frame.
  - IDLE: when `rx_s`=0, go to START.
  - START: at `cnt`==HALF_TICKS-1, sample the line.
    - Sample 1 (glitch): go to IDLE with no output.
    - Sample 0: `bit_idx`=0, go to DATA.
  - DATA: at `cnt`==BIT_TICKS-1, sample into `shift` and increment `bit_idx`. After the sample with `bit_idx`==7, go to STOP.
  - STOP: at `cnt`==BIT_TICKS-1, sample the line.
    - Sample 1: `data_out`<=`shift`, pulse `data_out_ready`, go to IDLE. The next start bit may follow with zero gap.
    - Sample 0: pulse `framing_error`, leave `data_out` unchanged, go to WAIT_IDLE. This covers break and misalignment.
- **Exclusivity:** `data_out_ready` and `framing_error` are never high together. Neither is ever high for two consecutive cycles.
- **Reset values:** `data_out`=0x00, `data_out_ready`=0, `framing_error`=0, state=WAIT_IDLE, `cnt`=0, `bit_idx`=0, `shift`=0x00, synchronizer flops=1.
- **Reset mid-frame:** the partial byte is discarded and no strobe is produced. The block re-arms only after a full bit time of idle.

## Timing

- Let T be the first cycle `rx_s`=0 while in IDLE. This is 2 cycles after the pin edge. START is entered at T+1.
- Sample points:
  - Start bit: T+800.
  - Data bit k (k=0..7): T+800+1600·(k+1).
  - Stop bit: T+15200.
- `data_out_ready` or `framing_error` is registered and high at T+15201. From pin edge to strobe is therefore 15203 cycles.
- Tolerance: the sample points stay inside each bit for transmitter baud error up to ±2%.
- Throughput: one byte per 16 000 cycles at back-to-back line rate. There is no backpressure; the consumer must accept every strobe.

## Configuration

- `MIDI_RX_MAJORITY_VOTE_EN` defined:
  - Each sample is the 2-of-3 majority of `rx_s` at `cnt`==N-3, N-2 and N-1, where N is HALF_TICKS or BIT_TICKS as applicable.
  - The decision is still taken at `cnt`==N-1, so timing is unchanged.
  - A single-cycle glitch at a sample point is rejected.
- Undefined: each sample is the single value of `rx_s` at `cnt`==N-1.

## Test plan

- **Single byte:** release reset, hold line high for 2000 cycles, send 0x90 → one `data_out_ready` pulse exactly 15203 cycles after the start edge, with `data_out`=0x90 and `framing_error` never high.
- **Back-to-back bytes:** send 0x90, 0x3C, 0x7F with no idle gap → three strobes, 16 000 cycles apart, with values 0x90, 0x3C, 0x7F.
- **Start glitch:** line low for 400 cycles, then high → no strobe; a valid 0x45 sent afterwards is received correctly.
- **Framing error:** send 0xA5 with the stop bit low, then hold the line low for 20 000 cycles, then high → one `framing_error` pulse at T+15201, no `data_out_ready`, `data_out` unchanged, no further strobes while low. A 0x12 sent 1600 or more cycles after release is received.
- **Reset mid-frame:** assert `reset` for 1 cycle at bit 4 of 0xFF → no strobe and all outputs at reset values. The remainder of the frame (line high) re-arms the block; the next byte 0x01 is received.
- **Majority vote (macro defined):** send 0x00 with a 1-cycle high pulse on `rx_s` at the bit-3 sample point → `data_out`=0x00. With the macro undefined → `data_out`=0x08.
